// File: rtl/dnn_block_feed_sequencer.sv
// Front-end sequencer for the DNN training engine: free-running block-cycle counter,
// block strobe, and combinational slicing of one training case into per-clock slots.
module dnn_block_feed_sequencer #(
  parameter int CPC      = 18,
  parameter int A_SLOT_W = 512,
  parameter int Y_SLOT_W = 1,
  parameter int N_A      = 16,
  parameter int N_Y      = 16,
  localparam int SEL_W   = $clog2(CPC - 2),
  localparam int CNT_W   = $clog2(CPC)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [N_A*A_SLOT_W-1:0] a,
  input  logic [N_Y*Y_SLOT_W-1:0] y,
  output logic [A_SLOT_W-1:0]     a_in,
  output logic [Y_SLOT_W-1:0]     y_in,
  output logic [CNT_W-1:0]        count,
  output logic [SEL_W-1:0]        sel_network,
  output logic                    cycle_clk,
  output logic                    out_valid
);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CPC - 1);

  generate
    if ((CPC - 2) < 2 || ((CPC - 2) & (CPC - 3)) != 0 || N_A != CPC - 2 || N_Y != CPC - 2) begin : g_bad_params
      $error("dnn_block_feed_sequencer: CPC-2 must be a power of two >= 2 and equal N_A and N_Y");
    end
  endgenerate

  logic [CNT_W-1:0]    r_count;
  logic                r_cycle_clk;
  logic [CNT_W-1:0]    w_count_nxt;
  logic [SEL_W-1:0]    w_sel;
  logic [A_SLOT_W-1:0] w_a_slots [N_A];
  logic [Y_SLOT_W-1:0] w_y_slots [N_Y];

  always_comb begin
    w_count_nxt = (r_count == LAST_CNT) ? '0 : r_count + CNT_W'(1);
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values; blocking here would create order-dependent simulation races.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_count     <= '0;
      r_cycle_clk <= 1'b0;
    end else begin
      r_count     <= w_count_nxt;
      // Strobe is registered off the next count so it is high exactly while count==CPC-1.
      r_cycle_clk <= (w_count_nxt == LAST_CNT);
    end
  end

  // Two-slot offset aligns the fed slot with the 2-clock drain at the block start.
  assign w_sel = r_count[SEL_W-1:0] - SEL_W'(2);

  for (genvar i = 0; i < N_A; i++) begin : g_a_slots
    assign w_a_slots[i] = a[i*A_SLOT_W +: A_SLOT_W];
  end
  for (genvar i = 0; i < N_Y; i++) begin : g_y_slots
    assign w_y_slots[i] = y[i*Y_SLOT_W +: Y_SLOT_W];
  end

  assign a_in        = w_a_slots[w_sel];
  assign y_in        = w_y_slots[w_sel];
  assign count       = r_count;
  assign sel_network = w_sel;
  assign cycle_clk   = r_cycle_clk;
  assign out_valid   = (r_count >= CNT_W'(2));

endmodule

// File: tb/tb_dnn_block_feed_sequencer.sv
// Scoreboard bench for dnn_block_feed_sequencer: a clocks-since-release model predicts
// every output; a negedge monitor pops predictions and compares (CPC=18 and CPC=6 instances).
module tb_dnn_block_feed_sequencer;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic [8191:0] a;
  logic [15:0]   y;
  logic [511:0]  a_in;
  logic          y_in;
  logic [4:0]    count;
  logic [3:0]    sel_network;
  logic          cycle_clk;
  logic          out_valid;

  logic [31:0]   a6;
  logic [7:0]    y6;
  logic [7:0]    a_in6;
  logic [1:0]    y_in6;
  logic [2:0]    count6;
  logic [1:0]    sel6;
  logic          cycle_clk6;
  logic          out_valid6;

  always #5 clk = ~clk;

  dnn_block_feed_sequencer dut (
    .clk(clk), .reset(reset), .a(a), .y(y), .a_in(a_in), .y_in(y_in),
    .count(count), .sel_network(sel_network), .cycle_clk(cycle_clk), .out_valid(out_valid)
  );

  dnn_block_feed_sequencer #(.CPC(6), .A_SLOT_W(8), .Y_SLOT_W(2), .N_A(4), .N_Y(4)) dut6 (
    .clk(clk), .reset(reset), .a(a6), .y(y6), .a_in(a_in6), .y_in(y_in6),
    .count(count6), .sel_network(sel6), .cycle_clk(cycle_clk6), .out_valid(out_valid6)
  );

  typedef struct {
    int           cnt;
    bit           cyc;
    int           sel;
    logic [511:0] a_in;
    logic         y_in;
    bit           ov;
    bit           chk;
    logic [15:0]  yv;
  } exp_t;

  typedef struct {
    int          cnt;
    bit          cyc;
    int          sel;
    logic [7:0]  a_in;
    logic [1:0]  y_in;
    bit          ov;
  } exp6_t;

  exp_t  q[$];
  exp6_t q6[$];

  logic [511:0] a_slots [16];
  logic         y_slots [16];
  logic [7:0]   a6_slots [4];
  logic [1:0]   y6_slots [4];

  int n = 0;
  bit blk_ok = 1'b0;
  int n_checks = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic void pack_inputs();
    for (int s = 0; s < 16; s++) begin
      a[s*512 +: 512] = a_slots[s];
      y[s]            = y_slots[s];
    end
    for (int s = 0; s < 4; s++) begin
      a6[s*8 +: 8] = a6_slots[s];
      y6[s*2 +: 2] = y6_slots[s];
    end
  endfunction

  function automatic void directed_case();
    logic [15:0] yc;
    yc = 16'hA5C3;
    for (int s = 0; s < 16; s++) begin
      a_slots[s] = {64{8'(s)}};
      y_slots[s] = yc[s];
    end
    for (int s = 0; s < 4; s++) begin
      a6_slots[s] = 8'(8'h10 + s);
      y6_slots[s] = 2'(s);
    end
    pack_inputs();
  endfunction

  function automatic void random_case();
    for (int s = 0; s < 16; s++) begin
      for (int w = 0; w < 16; w++) a_slots[s][w*32 +: 32] = $urandom;
      y_slots[s] = 1'($urandom);
    end
    for (int s = 0; s < 4; s++) begin
      a6_slots[s] = 8'($urandom);
      y6_slots[s] = 2'($urandom);
    end
    pack_inputs();
  endfunction

  // Prediction: count is simply clocks since reset release modulo the block length;
  // slot fed is two behind the count within the feed window.
  function automatic void push_expected(input bit changed);
    exp_t  e;
    exp6_t e6;
    int    c;
    c = n % 18;
    if (!reset) blk_ok = 1'b0;
    else if (c == 1) blk_ok = 1'b1;
    else if (changed && c >= 2) blk_ok = 1'b0;
    e.cnt  = c;
    e.cyc  = (c == 17);
    e.sel  = (c + 16 - 2) % 16;
    e.a_in = a_slots[e.sel];
    e.y_in = y_slots[e.sel];
    e.ov   = (c >= 2);
    e.chk  = (c == 17) && blk_ok;
    e.yv   = y;
    q.push_back(e);
    c = n % 6;
    e6.cnt  = c;
    e6.cyc  = (c == 5);
    e6.sel  = (c + 4 - 2) % 4;
    e6.a_in = a6_slots[e6.sel];
    e6.y_in = y6_slots[e6.sel];
    e6.ov   = (c >= 2);
    q6.push_back(e6);
  endfunction

  // mode: 0 keep inputs, 1 new random case, 2 new case on the clock after the strobe
  task automatic tick(input int mode, input bit rst_val);
    bit changed;
    @(posedge clk);
    #1;
    if (reset) n++;
    reset = rst_val;
    if (!reset) n = 0;
    changed = (mode == 1) || (mode == 2 && reset && (n % 18) == 0);
    if (changed) random_case();
    push_expected(changed);
  endtask

  logic [15:0] recon = 'x;

  always @(negedge clk) begin
    exp_t  e;
    exp6_t e6;
    if (q.size() > 0) begin
      e = q.pop_front();
      check("count", 512'(count), 512'(e.cnt));
      check("cycle_clk", 512'(cycle_clk), 512'(e.cyc));
      check("out_valid", 512'(out_valid), 512'(e.ov));
      check("sel_network", 512'(sel_network), 512'(e.sel));
      check("a_in", a_in, e.a_in);
      check("y_in", 512'(y_in), 512'(e.y_in));
      if (out_valid) recon[sel_network] = y_in;
      if (e.chk) check("y_reconstructed", 512'(recon), 512'(e.yv));
      if (e.cnt == 0) recon = 'x;
    end
    if (q6.size() > 0) begin
      e6 = q6.pop_front();
      check("count6", 512'(count6), 512'(e6.cnt));
      check("cycle_clk6", 512'(cycle_clk6), 512'(e6.cyc));
      check("out_valid6", 512'(out_valid6), 512'(e6.ov));
      check("sel6", 512'(sel6), 512'(e6.sel));
      check("a_in6", 512'(a_in6), 512'(e6.a_in));
      check("y_in6", 512'(y_in6), 512'(e6.y_in));
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    directed_case();
    reset = 1'b0;
    // Reset held, then 40 clocks of the fixed A5C3 case.
    tick(0, 1'b0);
    tick(0, 1'b0);
    tick(0, 1'b1);
    repeat (40) tick(0, 1'b1);

    // Reset landing mid-block, then a clean restart.
    while ((n % 18) != 9) tick(0, 1'b1);
    tick(0, 1'b0);
    tick(0, 1'b0);
    tick(0, 1'b1);
    repeat (40) tick(0, 1'b1);

    // New case one clock after each strobe for five blocks.
    repeat (5 * 18) tick(2, 1'b1);

    // Unconstrained input changes and occasional resets.
    repeat (250) begin
      if ($urandom_range(0, 59) == 0) begin
        repeat ($urandom_range(1, 3)) tick(0, 1'b0);
        tick(0, 1'b1);
      end else begin
        tick(($urandom_range(0, 2) == 0) ? 1 : 0, 1'b1);
      end
    end
    repeat (40) tick(2, 1'b1);

    @(negedge clk);
    @(negedge clk);
    check("scoreboard_drained", 512'(q.size() + q6.size()), 512'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
